bandwidth_tester_sequencer: RTL and testbench

- Kernel-level sequencer for the BandwidthTester kernel. It sits directly downstream of the AXI4-Lite control slave.
- It consumes `ap_start`, the size arguments and `kernel_command`, and returns `ap_done`/`ap_ready`/`ap_idle`.
- It repeatedly launches the input (mem→stream) and output (stream→mem) stages around the streaming core until no tokens move and the core is idle.
- It measures the run length in cycles for bandwidth reporting.

---
 rtl/bandwidth_tester_pkg.sv | 19 +
 rtl/bandwidth_tester_run_counter.sv | 27 ++
 rtl/bandwidth_tester_sequencer.sv | 156 +++++++++++++++
 tb/tb_bandwidth_tester_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bandwidth_tester_pkg.sv
// Shared types and constants for the BandwidthTester kernel sequencer.
package bandwidth_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_IO,
    ST_CHECK,
    ST_FINISH
  } state_t;

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
  localparam logic [1:0] STATUS_RUNNING = 2'd2;

  localparam int TIMEOUT_LSB = 0;
  localparam int TIMEOUT_MSB = 31;

endpackage

// File: rtl/bandwidth_tester_run_counter.sv
// Run-length cycle counter with clear/enable and a timeout-equality flag.
module bandwidth_tester_run_counter #(
  parameter int CNT_W = 64
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [31:0]      timeout,
  output logic [CNT_W-1:0] count,
  output logic             timeout_hit
);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // A zero timeout disables the check entirely.
  assign timeout_hit = (timeout != 32'd0) && (count == CNT_W'(timeout));

endmodule

// File: rtl/bandwidth_tester_sequencer.sv
// Kernel-level sequencer: relaunches the I/O stages until no tokens move and the core is idle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for ap_start, ap_idle high
// LAUNCH   | pulse both stage starts, bump iteration count
// WAIT_IO  | collect both stage done pulses in either order
// CHECK    | finish if nothing moved and the core is idle, else relaunch
// FINISH   | ap_done/ap_ready pulse visible, return to IDLE
module bandwidth_tester_sequencer
  import bandwidth_tester_pkg::*;
#(
  parameter int CNT_W  = 64,
  parameter int ITER_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  input  logic [31:0]       source_Out_pass_In_requested_size,
  input  logic [31:0]       pass_Out_sink_In_available_size,
  input  logic [63:0]       kernel_command,
  output logic              input_start,
  output logic [31:0]       input_req_size,
  input  logic              input_done,
  input  logic [31:0]       input_count,
  output logic              output_start,
  output logic [31:0]       output_avail_size,
  input  logic              output_done,
  input  logic [31:0]       output_count,
  input  logic              core_idle,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [ITER_W-1:0] run_iters,
  output logic [1:0]        run_status
);

  state_t      state;
  logic [31:0] timeout;
  logic [31:0] in_cap;
  logic [31:0] out_cap;
  logic        in_seen;
  logic        out_seen;
  logic        in_got;
  logic        out_got;
  logic        timeout_hit;
  logic        cnt_clear;
  logic        cnt_enable;
  logic        unused_cmd_hi;

  assign unused_cmd_hi = ^kernel_command[63:32];

  assign cnt_clear  = (state == ST_IDLE) && ap_start;
  assign cnt_enable = (state != ST_IDLE);
  assign in_got     = in_seen | input_done;
  assign out_got    = out_seen | output_done;

  bandwidth_tester_run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .clear       (cnt_clear),
    .enable      (cnt_enable),
    .timeout     (timeout),
    .count       (run_cycles),
    .timeout_hit (timeout_hit)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state             <= ST_IDLE;
      ap_done           <= 1'b0;
      ap_ready          <= 1'b0;
      ap_idle           <= 1'b1;
      input_start       <= 1'b0;
      output_start      <= 1'b0;
      input_req_size    <= '0;
      output_avail_size <= '0;
      timeout           <= '0;
      in_cap            <= '0;
      out_cap           <= '0;
      in_seen           <= 1'b0;
      out_seen          <= 1'b0;
      run_iters         <= '0;
      run_status        <= STATUS_OK;
    end else begin
      ap_done      <= 1'b0;
      ap_ready     <= 1'b0;
      input_start  <= 1'b0;
      output_start <= 1'b0;
      // Timeout wins over any stage activity in the same cycle.
      if (timeout_hit && (state != ST_IDLE) && (state != ST_FINISH)) begin
        state      <= ST_FINISH;
        run_status <= STATUS_TIMEOUT;
        ap_done    <= 1'b1;
        ap_ready   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ap_start) begin
              input_req_size    <= source_Out_pass_In_requested_size;
              output_avail_size <= pass_Out_sink_In_available_size;
              timeout           <= kernel_command[TIMEOUT_MSB:TIMEOUT_LSB];
              run_iters         <= '0;
              run_status        <= STATUS_RUNNING;
              ap_idle           <= 1'b0;
              state             <= ST_LAUNCH;
            end
          end
          ST_LAUNCH: begin
            input_start  <= 1'b1;
            output_start <= 1'b1;
            in_seen      <= 1'b0;
            out_seen     <= 1'b0;
            if (run_iters != '1) begin
              run_iters <= run_iters + ITER_W'(1);
            end
            state <= ST_WAIT_IO;
          end
          ST_WAIT_IO: begin
            if (input_done) begin
              in_seen <= 1'b1;
              in_cap  <= input_count;
            end
            if (output_done) begin
              out_seen <= 1'b1;
              out_cap  <= output_count;
            end
            if (in_got && out_got) begin
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if ((in_cap == 32'd0) && (out_cap == 32'd0) && core_idle) begin
              run_status <= STATUS_OK;
              ap_done    <= 1'b1;
              ap_ready   <= 1'b1;
              state      <= ST_FINISH;
            end else begin
              state <= ST_LAUNCH;
            end
          end
          ST_FINISH: begin
            ap_idle <= 1'b1;
            state   <= ST_IDLE;
          end
          default: begin
            ap_idle <= 1'b1;
            state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bandwidth_tester_sequencer.sv
// Bench for bandwidth_tester_sequencer: directed vector table, reset sequences, randomized runs.
module tb_bandwidth_tester_sequencer;

  localparam int CNT_W  = 64;
  localparam int ITER_W = 32;
  localparam int NEVER  = 1 << 30;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              ap_start;
  logic              ap_done;
  logic              ap_ready;
  logic              ap_idle;
  logic [31:0]       req_size;
  logic [31:0]       avail_size;
  logic [63:0]       kernel_command;
  logic              input_start;
  logic [31:0]       input_req_size;
  logic              input_done;
  logic [31:0]       input_count;
  logic              output_start;
  logic [31:0]       output_avail_size;
  logic              output_done;
  logic [31:0]       output_count;
  logic              core_idle;
  logic [CNT_W-1:0]  run_cycles;
  logic [ITER_W-1:0] run_iters;
  logic [1:0]        run_status;

  bandwidth_tester_sequencer #(.CNT_W(CNT_W), .ITER_W(ITER_W)) dut (
    .ap_clk                            (ap_clk),
    .ap_rst_n                          (ap_rst_n),
    .ap_start                          (ap_start),
    .ap_done                           (ap_done),
    .ap_ready                          (ap_ready),
    .ap_idle                           (ap_idle),
    .source_Out_pass_In_requested_size (req_size),
    .pass_Out_sink_In_available_size   (avail_size),
    .kernel_command                    (kernel_command),
    .input_start                       (input_start),
    .input_req_size                    (input_req_size),
    .input_done                        (input_done),
    .input_count                       (input_count),
    .output_start                      (output_start),
    .output_avail_size                 (output_avail_size),
    .output_done                       (output_done),
    .output_count                      (output_count),
    .core_idle                         (core_idle),
    .run_cycles                        (run_cycles),
    .run_iters                         (run_iters),
    .run_status                        (run_status)
  );

  // One scenario: sizes, timeout, and per-iteration stage behaviour (delay 0 = never answers).
  typedef struct packed {
    logic [31:0]      req;
    logic [31:0]      avail;
    logic [31:0]      tmo;
    int               n;
    logic [3:0][7:0]  d_in;
    logic [3:0][7:0]  d_out;
    logic [3:0][31:0] c_in;
    logic [3:0][31:0] c_out;
    logic [3:0]       idle;
  } scen_t;

  typedef struct packed {
    int         done_ofs;
    int         iters;
    logic [1:0] status;
  } exp_t;

  typedef struct packed {
    scen_t s;
    exp_t  e;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  vec_t vecs[$];

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_idle"},      64'(ap_idle), 64'(1));
    chk({tag, "_done"},      64'(ap_done), 64'(0));
    chk({tag, "_ready"},     64'(ap_ready), 64'(0));
    chk({tag, "_starts"},    64'({input_start, output_start}), 64'(0));
    chk({tag, "_cycles"},    64'(run_cycles), 64'(0));
    chk({tag, "_iters"},     64'(run_iters), 64'(0));
    chk({tag, "_status"},    64'(run_status), 64'(0));
    chk({tag, "_sizes"},     {input_req_size, output_avail_size}, 64'(0));
  endtask

  function automatic scen_t base(input logic [31:0] req, input logic [31:0] avail,
                                 input logic [31:0] tmo);
    scen_t s;
    s = '0;
    s.req   = req;
    s.avail = avail;
    s.tmo   = tmo;
    return s;
  endfunction

  function automatic scen_t iter(input scen_t si, input int din, input int dout,
                                 input logic [31:0] cin, input logic [31:0] cout, input bit idl);
    scen_t s;
    s = si;
    s.d_in[s.n[1:0]]  = 8'(din);
    s.d_out[s.n[1:0]] = 8'(dout);
    s.c_in[s.n[1:0]]  = cin;
    s.c_out[s.n[1:0]] = cout;
    s.idle[s.n[1:0]]  = idl;
    s.n = s.n + 1;
    return s;
  endfunction

  function automatic vec_t mkv(input scen_t s, input int ofs, input int iters, input logic [1:0] st);
    vec_t v;
    v.s = s;
    v.e.done_ofs = ofs;
    v.e.iters    = iters;
    v.e.status   = st;
    return v;
  endfunction

  // Reference: schedule of launch pulses and the finish cycle, relative to the ap_start cycle.
  // A launch pulse appears 2 cycles after start or 2 cycles after the previous CHECK; CHECK
  // follows the later done by one cycle; ap_done appears the cycle after a successful CHECK.
  // A timeout T is hit at offset T+1 and gives ap_done at T+2 unless FINISH already came.
  function automatic exp_t model(input scen_t s);
    exp_t e;
    int   launch_at[4];
    int   l;
    int   f;
    int   np;
    int   m;
    l  = 2;
    f  = NEVER;
    np = 0;
    for (int k = 0; k < s.n; k++) begin
      launch_at[k] = l;
      np++;
      if (s.d_in[k] == 8'd0 || s.d_out[k] == 8'd0) break;
      m = (s.d_in[k] > s.d_out[k]) ? int'(s.d_in[k]) : int'(s.d_out[k]);
      if (k == s.n - 1) f = l + m + 2;
      else l = l + m + 3;
    end
    e.done_ofs = f;
    e.iters    = np;
    e.status   = 2'd0;
    if (s.tmo != 32'd0 && int'(s.tmo) + 2 <= f) begin
      e.done_ofs = int'(s.tmo) + 2;
      e.status   = 2'd1;
      e.iters    = 0;
      for (int k = 0; k < np; k++) begin
        if (launch_at[k] - 1 < int'(s.tmo) + 1) e.iters++;
      end
    end
    return e;
  endfunction

  // Drives one run from the current (idle) cycle, playing the stages, then checks the outcome.
  task automatic run_vec(input string nm, input scen_t s, input exp_t e);
    int          t;
    int          k;
    int          in_due;
    int          out_due;
    int          done_cyc;
    int          ndone;
    int          n_in;
    int          n_out;
    int          rdy_bad;
    logic [31:0] ci;
    logic [31:0] co;
    logic [1:0]  st_at;
    logic [63:0] it_at;
    logic [63:0] rc_at;
    logic [63:0] sz_at;
    logic        idle_after;
    t = cyc;  k = 0;  in_due = -1;  out_due = -1;  done_cyc = -1;
    ndone = 0;  n_in = 0;  n_out = 0;  rdy_bad = 0;  ci = '0;  co = '0;
    st_at = '0;  it_at = '0;  rc_at = '0;  sz_at = '0;  idle_after = 1'b0;
    req_size       = s.req;
    avail_size     = s.avail;
    kernel_command = {$urandom, s.tmo};
    ap_start       = 1'b1;
    for (int b = 0; b < 400; b++) begin
      tick();
      if (cyc == t + 1) chk({nm, "_idle_low"}, 64'(ap_idle), 64'(0));
      if (done_cyc >= 0 && cyc == done_cyc + 1) idle_after = ap_idle;
      if (ap_ready !== ap_done) rdy_bad++;
      if (output_start) n_out++;
      if (input_start) begin
        n_in++;
        if (k < s.n) begin
          in_due    = (s.d_in[k] == 8'd0) ? NEVER : cyc + int'(s.d_in[k]);
          out_due   = (s.d_out[k] == 8'd0) ? NEVER : cyc + int'(s.d_out[k]);
          ci        = s.c_in[k];
          co        = s.c_out[k];
          core_idle = s.idle[k];
          k++;
        end
      end
      if (ap_done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          st_at    = run_status;
          it_at    = 64'(run_iters);
          rc_at    = run_cycles;
          sz_at    = {input_req_size, output_avail_size};
        end
        ap_start = 1'b0;
      end
      input_done   = (cyc == in_due);
      input_count  = input_done ? ci : $urandom;
      output_done  = (cyc == out_due);
      output_count = output_done ? co : $urandom;
      if (done_cyc >= 0 && cyc >= done_cyc + 4 &&
          (in_due == NEVER || cyc > in_due) && (out_due == NEVER || cyc > out_due)) break;
    end
    ap_start    = 1'b0;
    input_done  = 1'b0;
    output_done = 1'b0;
    if (done_cyc < 0) begin
      chk({nm, "_done_seen"}, 64'(0), 64'(1));
    end else begin
      chk({nm, "_done_ofs"},    64'(done_cyc - t), 64'(e.done_ofs));
      chk({nm, "_status"},      64'(st_at), 64'(e.status));
      chk({nm, "_iters"},       it_at, 64'(e.iters));
      chk({nm, "_cyc_at_done"}, rc_at, 64'(e.done_ofs - 1));
      chk({nm, "_sizes"},       sz_at, {s.req, s.avail});
      chk({nm, "_idle_after"},  64'(idle_after), 64'(1));
    end
    chk({nm, "_in_launches"},  64'(n_in), 64'(e.iters));
    chk({nm, "_out_launches"}, 64'(n_out), 64'(e.iters));
    chk({nm, "_ndone"},        64'(ndone), 64'(1));
    chk({nm, "_ready_match"},  64'(rdy_bad), 64'(0));
    chk({nm, "_cyc_held"},     run_cycles, 64'(e.done_ofs));
    chk({nm, "_status_held"},  64'(run_status), 64'(e.status));
  endtask

  initial begin
    scen_t s;
    scen_t r;
    int    ndone;
    ap_rst_n = 1'b0;  ap_start = 1'b0;  req_size = '0;  avail_size = '0;
    kernel_command = '0;  input_done = 1'b0;  input_count = '0;
    output_done = 1'b0;  output_count = '0;  core_idle = 1'b1;

    // Directed table: {scenario, expected done offset / iterations / status}
    vecs.push_back(mkv(iter(base(16, 16, 0), 1, 1, 0, 0, 1), 5, 1, 2'd0));
    s = base(16, 16, 0);
    for (int i = 0; i < 3; i++) s = iter(s, 1, 1, 16, 16, 1);
    vecs.push_back(mkv(iter(s, 1, 1, 0, 0, 1), 17, 4, 2'd0));
    vecs.push_back(mkv(iter(base(7, 9, 0), 11, 1, 0, 0, 1), 15, 1, 2'd0));
    vecs.push_back(mkv(iter(base(7, 9, 0), 3, 3, 0, 0, 1), 7, 1, 2'd0));
    vecs.push_back(mkv(iter(iter(base(16, 16, 0), 1, 1, 0, 0, 0), 1, 1, 0, 0, 1), 9, 2, 2'd0));
    vecs.push_back(mkv(iter(base(16, 16, 20), 30, 0, 0, 0, 1), 22, 1, 2'd1));
    vecs.push_back(mkv(iter(base(8, 4, 0), 2, 1, 0, 0, 1), 6, 1, 2'd0));
    vecs.push_back(mkv(iter(base(1, 2, 3), 1, 1, 0, 0, 1), 5, 1, 2'd1));
    vecs.push_back(mkv(iter(base(1, 2, 4), 1, 1, 0, 0, 1), 5, 1, 2'd0));
    vecs.push_back(mkv(iter(iter(base(3, 5, 0), 2, 4, 5, 0, 1), 1, 2, 0, 0, 1), 13, 2, 2'd0));

    repeat (3) tick();
    chk_reset_vals("por");
    ap_rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);
    end

    // Reset while waiting on stages that never answer: no ap_done, then a clean run.
    req_size = 32'd5;  avail_size = 32'd6;  kernel_command = '0;  ap_start = 1'b1;
    repeat (3) tick();
    ap_start = 1'b0;
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    chk_reset_vals("midrst");
    ndone = 0;
    repeat (8) begin
      tick();
      if (ap_done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'(0));
    chk("midrst_idle", 64'(ap_idle), 64'(1));
    run_vec("post_rst", vecs[0].s, vecs[0].e);

    // Randomized runs checked against the schedule model.
    for (int i = 0; i < 25; i++) begin
      int n;
      r = base($urandom, $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 60)) : 32'd0);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n - 1; k++) begin
        logic [31:0] cin;
        logic [31:0] cout;
        cin  = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(1, 50));
        cout = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(1, 50));
        r = iter(r, $urandom_range(1, 8), $urandom_range(1, 8), cin, cout,
                 (cin == 0 && cout == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      end
      r = iter(r, $urandom_range(1, 8), $urandom_range(1, 8), 0, 0, 1'b1);
      run_vec($sformatf("rnd%0d", i), r, model(r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
